uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clk cycles per serial bit (100 MHz / 115200 baud); legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 4, byte entries in the transmit queue; power of two, at least 2.
REQ-003 Port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 Port rstn  input  1  synchronous active-high reset; 1 = reset, sampled on the rising edge of clk.
REQ-005 Port txdata  input  8  byte to transmit, driven from the core's source register low byte.
REQ-006 Port tx_valid  input  1  producer offers txdata this cycle.
REQ-007 Port tx_ready  output  1  queue can accept a byte this cycle.
REQ-008 Port txd  output  1  serial line, idle high.
REQ-009 Port busy  output  1  frame in progress or queue non-empty.

Function
REQ-010 A byte SHALL be accepted on a rising edge where tx_valid=1 and tx_ready=1; txdata SHALL be captured on that edge.
REQ-011 tx_ready SHALL be 1 exactly when the queue holds fewer than FIFO_DEPTH bytes, combinationally from the occupancy count, independent of tx_valid.
REQ-012 With tx_valid=1 and tx_ready=0, nothing SHALL be captured and the queue SHALL not change.
REQ-013 Bytes SHALL be transmitted in acceptance order; none dropped or duplicated.
REQ-014 Serializer states: IDLE, START, DATA, STOP.
REQ-015 IDLE: txd=1; when the queue is non-empty, pop the head into the shift register and enter START on that edge.
REQ-016 START: txd=0 for CLKS_PER_BIT cycles, then DATA.
REQ-017 DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles; a 3-bit bit index counts 0..7, then STOP.
REQ-018 STOP: txd=1 for CLKS_PER_BIT cycles; on the last cycle, if the queue is non-empty, pop and enter START directly with no idle cycle; otherwise enter IDLE.
REQ-019 One frame SHALL occupy exactly 10*CLKS_PER_BIT cycles; the baud counter SHALL count 0..CLKS_PER_BIT-1 and wrap, reloading to 0 at each state change.
REQ-020 Latency: for a byte accepted at edge N with IDLE and the queue empty, txd SHALL be 0 from edge N+2.
REQ-021 A simultaneous push and pop SHALL leave occupancy unchanged, including at occupancy 1 when the serializer pops in the same cycle.
REQ-022 When full, a pop SHALL raise tx_ready in the following cycle; same-cycle push on full is not permitted.
REQ-023 Queue pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL use log2(FIFO_DEPTH)+1 bits to distinguish full from empty.
REQ-024 busy SHALL be 1 when the state is not IDLE or occupancy is not 0.
REQ-025 txd SHALL be registered (glitch-free).

Reset
REQ-026 While rstn=1 at an edge: state IDLE, txd=1, occupancy 0, pointers 0, baud counter 0, bit index 0; hence tx_ready=1 and busy=0 after that edge.
REQ-027 Reset mid-frame SHALL abort the frame (txd=1 from the next edge) and discard all queued bytes.
REQ-028 tx_valid during reset SHALL be ignored.

Structure
REQ-029 Package uart_pkg SHALL hold the serializer state enum, default CLKS_PER_BIT and FIFO_DEPTH constants, and the frame-length constant 10.
REQ-030 The queue SHALL be a sub-module sync_fifo (parameter depth, width 8), with push/pop/full/empty/count ports, same clk and reset.
REQ-031 The serializer FSM, baud counter and shift register SHALL reside in uart_tx.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-032 Reset, then send 0x55 -> txd low at edge N+2, then bits 1,0,1,0,1,0,1,0, then stop high, each bit 4 cycles; 40 cycles total; busy falls after stop.
REQ-033 Push 0xA5, 0x3C back-to-back -> two frames with no idle gap between the stop of the first and the start of the second; bits decode to 0xA5, 0x3C.
REQ-034 Hold tx_valid=1 with 0x00..0x09 -> tx_ready falls at full; bytes are accepted only when tx_ready=1; sampled line decodes 0x00..0x09 in order with none lost.
REQ-035 Occupancy 1, serializer pops while a push arrives in the same cycle -> occupancy stays 1; order is preserved.
REQ-036 Assert rstn in the DATA state of 0xFF with 3 bytes queued -> txd=1 the next cycle, tx_ready=1, busy=0; no further frames are sent.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the uart_tx transmitter.
// Revision    : 1.0 - initial release
// ============================================================================

package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    localparam int unsigned c_DEFAULT_CLKS_PER_BIT = 868;
    localparam int unsigned c_DEFAULT_FIFO_DEPTH   = 4;
    localparam int unsigned c_FRAME_BITS           = 10;
    // Start and stop bits frame the payload.
    localparam int unsigned c_DATA_BITS            = c_FRAME_BITS - 2;

    // Serial line level driven while the serializer sits in a given state.
    function automatic logic line_level(input uart_state_e st, input logic data_bit);
        logic lvl;
        case (st)
            ST_START: lvl = 1'b0;
            ST_DATA:  lvl = data_bit;
            default:  lvl = 1'b1;
        endcase
        return lvl;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock byte queue with occupancy count, full and empty.
// Revision    : 1.0 - initial release
// ============================================================================

module sync_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned            c_PTR_W = $clog2(DEPTH);
    localparam int unsigned            c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0]     c_DEPTH = c_CNT_W'(DEPTH);

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [c_PTR_W-1:0] wr_ptr_q;
    logic [c_PTR_W-1:0] rd_ptr_q;
    logic [c_CNT_W-1:0] count_q;

    logic w_push;
    logic w_pop;

    assign full_o  = (count_q == c_DEPTH);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Requests are qualified here so a stray push on full or pop on empty is inert.
    assign w_push = push_i & ~full_o;
    assign w_pop  = pop_i  & ~empty_o;

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : 8N1 UART transmitter with a small byte queue in front.
// Revision    : 1.0 - initial release
// ============================================================================

module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = c_DEFAULT_CLKS_PER_BIT,
    parameter int unsigned FIFO_DEPTH   = c_DEFAULT_FIFO_DEPTH
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] txdata,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       txd,
    output logic       busy
);

    localparam int unsigned c_CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] c_BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  c_BIT_LAST  = 3'(c_DATA_BITS - 1);

    uart_state_e  state_q, state_d;
    logic [15:0]  baud_q,  baud_d;
    logic [2:0]   bit_q,   bit_d;
    logic [7:0]   shift_q, shift_d;
    logic         txd_q;

    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic [7:0]         w_head;
    logic [c_CNT_W-1:0] w_count;
    logic               w_baud_last;

    assign tx_ready = ~w_full;
    assign w_push   = tx_valid & tx_ready;
    assign txd      = txd_q;
    assign busy     = (state_q != ST_IDLE) || (w_count != '0);

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (w_push),
        .wdata_i (txdata),
        .pop_i   (w_pop),
        .rdata_o (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (w_count)
    );

    assign w_baud_last = (baud_q == c_BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + 16'd1;
        bit_d   = bit_q;
        shift_d = shift_q;
        w_pop   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                if (!w_empty) begin
                    w_pop   = 1'b1;
                    shift_d = w_head;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (w_baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_baud_last) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == c_BIT_LAST) begin
                        bit_d   = '0;
                        state_d = ST_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (w_baud_last) begin
                    baud_d = '0;
                    // Chain straight into the next frame so back-to-back bytes have no idle gap.
                    if (!w_empty) begin
                        w_pop   = 1'b1;
                        shift_d = w_head;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                baud_d  = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            // The line follows the current state one cycle later, glitch-free.
            txd_q   <= line_level(state_q, shift_q[0]);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx
// Description : Self-checking bench for uart_tx with a frame-level line model.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_uart_tx;
    import uart_pkg::*;

    localparam int CPB       = 4;
    localparam int DEPTH     = 4;
    localparam int FRAME_CYC = c_FRAME_BITS * CPB;

    logic       clk;
    logic       rstn;
    logic [7:0] txdata;
    logic       tx_valid;
    logic       tx_ready;
    logic       txd;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    logic [7:0] exp_q [$];
    int         starts [$];
    int         n_frames = 0;
    bit         in_frame = 0;
    int         idx      = 0;
    logic [7:0] cur_byte = 8'h00;

    uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .txdata   (txdata),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .txd      (txd),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Ideal 8N1 line level at cycle i of a frame carrying byte b.
    function automatic logic exp_bit(input logic [7:0] b, input int i);
        int slot;
        slot = i / CPB;
        if (slot == 0) return 1'b0;
        if (slot == c_FRAME_BITS - 1) return 1'b1;
        return b[slot - 1];
    endfunction

    // Line model: record accepted bytes, then check every cycle of each frame.
    always @(negedge clk) begin
        if (rstn) begin
            exp_q.delete();
            in_frame = 0;
        end else begin
            if (tx_valid && tx_ready) exp_q.push_back(txdata);
            if (in_frame) begin
                check("txd_frame", {31'd0, txd}, {31'd0, exp_bit(cur_byte, idx)});
                idx++;
                if (idx == FRAME_CYC) in_frame = 0;
            end else if (txd == 1'b0) begin
                check("frame_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    cur_byte = exp_q.pop_front();
                    in_frame = 1;
                    idx      = 1;
                    starts.push_back(cyc);
                    n_frames++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        int   guard;
        logic acc;
        guard    = 0;
        acc      = 1'b0;
        tx_valid = 1'b1;
        txdata   = b;
        while (!acc && guard < 200) begin
            @(negedge clk);
            acc = tx_ready;
            step();
            guard++;
        end
        tx_valid = 1'b0;
        if (!acc) check("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle(input string tag, input int bound);
        bit done;
        done = 0;
        for (int k = 0; k < bound && !done; k++) begin
            step();
            if (exp_q.size() == 0 && !in_frame && !busy) done = 1;
        end
        check({"idle_", tag}, {31'd0, done}, 32'd1);
        repeat (3) step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int v;
        int nacc;
        int f0;
        logic [7:0] b;

        rstn     = 1'b1;
        tx_valid = 1'b1;
        txdata   = 8'h99;
        repeat (3) step();
        check("rst_ready", {31'd0, tx_ready}, 32'd1);
        check("rst_busy",  {31'd0, busy},     32'd0);
        check("rst_txd",   {31'd0, txd},      32'd1);
        rstn     = 1'b0;
        tx_valid = 1'b0;
        repeat (5) step();
        check("post_rst_busy", {31'd0, busy}, 32'd0);

        // Single frame: latency and busy envelope.
        push_byte(8'h55);
        step();
        check("lat_n1_txd", {31'd0, txd}, 32'd1);
        step();
        check("lat_n2_txd", {31'd0, txd}, 32'd0);
        check("frame_busy", {31'd0, busy}, 32'd1);
        repeat (38) step();
        check("stop_busy", {31'd0, busy}, 32'd1);
        repeat (2) step();
        check("end_busy", {31'd0, busy}, 32'd0);
        check("end_txd",  {31'd0, txd},  32'd1);
        wait_idle("single", 200);
        check("single_frames", n_frames, 32'd1);

        // Back-to-back frames must abut exactly.
        f0 = n_frames;
        push_byte(8'hA5);
        push_byte(8'h3C);
        wait_idle("b2b", 300);
        check("b2b_frames", n_frames - f0, 32'd2);
        if (starts.size() >= 2)
            check("b2b_gap", starts[starts.size()-1] - starts[starts.size()-2], FRAME_CYC);

        // Hold valid high: one byte in flight plus a full queue, then backpressure.
        f0       = n_frames;
        v        = 0;
        nacc     = 0;
        tx_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            txdata = 8'(v);
            @(negedge clk);
            if (tx_ready) begin v++; nacc++; end
            step();
        end
        check("burst_fill",  nacc, DEPTH + 1);
        check("burst_ready", {31'd0, tx_ready}, 32'd0);
        for (int k = 0; k < 2000 && v < 10; k++) begin
            txdata = 8'(v);
            @(negedge clk);
            if (tx_ready) v++;
            step();
        end
        tx_valid = 1'b0;
        check("burst_count", v, 32'd10);
        wait_idle("burst", 1000);
        check("burst_frames", n_frames - f0, 32'd10);

        // Push lands on the same edge the serializer pops the only entry.
        f0 = n_frames;
        for (int k = 0; k < 5; k++) begin
            push_byte(8'($urandom));
            if (k == 3) check("pp_ready_cnt3", {31'd0, tx_ready}, 32'd1);
            if (k == 4) check("pp_ready_full", {31'd0, tx_ready}, 32'd0);
        end
        wait_idle("pushpop", 600);
        check("pushpop_frames", n_frames - f0, 32'd5);

        // Random traffic with random gaps.
        f0 = n_frames;
        for (int k = 0; k < 24; k++) begin
            repeat ($urandom_range(0, 50)) step();
            push_byte(8'($urandom));
        end
        wait_idle("random", 2000);
        check("random_frames", n_frames - f0, 32'd24);

        // Reset mid-DATA with bytes still queued.
        push_byte(8'hFF);
        for (int k = 0; k < 3; k++) push_byte(8'($urandom));
        repeat (12) step();
        b        = 8'($urandom);
        rstn     = 1'b1;
        tx_valid = 1'b1;
        txdata   = b;
        step();
        check("abort_txd",   {31'd0, txd},      32'd1);
        check("abort_ready", {31'd0, tx_ready}, 32'd1);
        check("abort_busy",  {31'd0, busy},     32'd0);
        rstn     = 1'b0;
        tx_valid = 1'b0;
        f0       = n_frames;
        repeat (150) step();
        check("abort_no_frames", n_frames - f0, 32'd0);
        check("abort_quiet_busy", {31'd0, busy}, 32'd0);
        check("abort_quiet_txd",  {31'd0, txd},  32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
